aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule. Produces one 128-bit round key per clock,

---
 rtl/aes_key_expand.sv | 169 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, streamed out in order
// and retained in an 11-entry store for random-access reads by the inverse cipher.
module aes_key_expand #(
    parameter int NR       = 10,
    parameter bit STORE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [3:0]   rcon_round,
    input  logic [31:0]  rcon_word,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] rk_data,
    output logic         done,
    output logic         keys_ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] FIN    = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    logic [1:0]   state_reg;
    logic [127:0] w_reg;
    logic [3:0]   r_reg;
    logic         busy_reg;
    logic         rk_valid_reg;
    logic [3:0]   rk_index_reg;
    logic [127:0] rk_data_reg;
    logic         done_reg;
    logic         keys_ready_reg;

    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [127:0] w_next;

    assign rot_word = {w_reg[23:0], w_reg[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_subword
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    // Each new word chains off the one just produced, so n3 depends on all of t, w0..w3.
    always_comb begin
        t_word           = sub_word ^ rcon_word;
        w_next[127:96]   = w_reg[127:96] ^ t_word;
        w_next[95:64]    = w_reg[95:64]  ^ w_next[127:96];
        w_next[63:32]    = w_reg[63:32]  ^ w_next[95:64];
        w_next[31:0]     = w_reg[31:0]   ^ w_next[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            w_reg          <= '0;
            r_reg          <= '0;
            busy_reg       <= 1'b0;
            rk_valid_reg   <= 1'b0;
            rk_index_reg   <= '0;
            rk_data_reg    <= '0;
            done_reg       <= 1'b0;
            keys_ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_reg          <= key_in;
                        r_reg          <= '0;
                        busy_reg       <= 1'b1;
                        keys_ready_reg <= 1'b0;
                        state_reg      <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk_valid_reg <= 1'b1;
                    rk_index_reg <= r_reg;
                    rk_data_reg  <= w_reg;
                    w_reg        <= w_next;
                    if (r_reg == LAST_ROUND) begin
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end else begin
                        r_reg <= r_reg + 4'd1;
                    end
                end
                FIN: begin
                    done_reg       <= 1'b0;
                    rk_valid_reg   <= 1'b0;
                    busy_reg       <= 1'b0;
                    keys_ready_reg <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        if (STORE_EN) begin : gen_store
            logic [127:0] store_reg [0:10];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i <= 10; i++) begin
                        store_reg[i] <= '0;
                    end
                end else if (state_reg == EXPAND) begin
                    for (int i = 0; i <= 10; i++) begin
                        if (r_reg == 4'(i)) begin
                            store_reg[i] <= w_reg;
                        end
                    end
                end
            end

            always_comb begin
                rd_key = '0;
                if (rd_idx <= 4'd10) begin
                    rd_key = store_reg[rd_idx];
                end
            end
        end else begin : gen_no_store
            assign rd_key = '0;
        end
    endgenerate

    assign rcon_round = r_reg;
    assign busy       = busy_reg;
    assign rk_valid   = rk_valid_reg;
    assign rk_index   = rk_index_reg;
    assign rk_data    = rk_data_reg;
    assign done       = done_reg;
    assign keys_ready = keys_ready_reg;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus queues the expected key stream,
// a negedge monitor pops and compares every presented round key.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rcon_round;
    logic [31:0]  rcon_word;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] rk_data;
    logic         done;
    logic         keys_ready;
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10), .STORE_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .rcon_round (rcon_round),
        .rcon_word  (rcon_word),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_index   (rk_index),
        .rk_data    (rk_data),
        .done       (done),
        .keys_ready (keys_ready),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always_comb begin
        case (rcon_round)
            4'd0:    rcon_word = 32'h01000000;
            4'd1:    rcon_word = 32'h02000000;
            4'd2:    rcon_word = 32'h04000000;
            4'd3:    rcon_word = 32'h08000000;
            4'd4:    rcon_word = 32'h10000000;
            4'd5:    rcon_word = 32'h20000000;
            4'd6:    rcon_word = 32'h40000000;
            4'd7:    rcon_word = 32'h80000000;
            4'd8:    rcon_word = 32'h1b000000;
            4'd9:    rcon_word = 32'h36000000;
            default: rcon_word = 32'h00000000;
        endcase
    end

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    logic [127:0] fips_tab [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] zero_tab [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: one popped expectation per presented key.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rk_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_key: got idx %0d, expected no key", rk_index);
                end else begin
                    e = sb_q.pop_front();
                    $display("key idx %0d data %h done %0b", rk_index, rk_data, done);
                    check("rk_index", 128'(rk_index), 128'(e.idx));
                    check("rk_data", rk_data, e.data);
                    check("done_flag", 128'(done), 128'(e.idx == 4'd10));
                    if (done) check("done_latency", 128'(cyc - accept_cyc), 128'd11);
                end
            end else if (done) begin
                check("done_without_valid", 128'(done), 128'd0);
            end
            if (done) done_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [127:0] k, input bit is_zero);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        accept_cyc = cyc;
        for (int i = 0; i <= 10; i++) begin
            exp_t e;
            e.idx  = 4'(i);
            e.data = is_zero ? zero_tab[i] : fips_tab[i];
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, n);
        end
    endtask

    task automatic post_checks(input string name, input int d0);
        @(negedge clk);
        check({name, "_busy"}, 128'(busy), 128'd0);
        check({name, "_rk_valid"}, 128'(rk_valid), 128'd0);
        check({name, "_keys_ready"}, 128'(keys_ready), 128'd1);
        check({name, "_queue"}, 128'(sb_q.size()), 128'd0);
        check({name, "_done_pulses"}, 128'(done_cnt - d0), 128'd1);
    endtask

    task automatic sweep(input string name, input bit is_zero);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            if (i <= 10) check(name, rd_key, is_zero ? zero_tab[i] : fips_tab[i]);
            else         check(name, rd_key, 128'd0);
        end
        rd_idx = '0;
        @(negedge clk);
    endtask

    task automatic reset_outputs(input string name);
        check({name, "_busy"}, 128'(busy), 128'd0);
        check({name, "_rk_valid"}, 128'(rk_valid), 128'd0);
        check({name, "_done"}, 128'(done), 128'd0);
        check({name, "_keys_ready"}, 128'(keys_ready), 128'd0);
        check({name, "_rk_index"}, 128'(rk_index), 128'd0);
        check({name, "_rk_data"}, rk_data, 128'd0);
        check({name, "_rcon_round"}, 128'(rcon_round), 128'd0);
        check({name, "_store0"}, rd_key, 128'd0);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 key, then read back the whole store
        d0 = done_cnt;
        issue(FIPS_KEY, 1'b0);
        check("fips_busy", 128'(busy), 128'd1);
        check("fips_keys_ready_cleared", 128'(keys_ready), 128'd0);
        wait_done("fips");
        post_checks("fips", d0);
        sweep("fips_store", 1'b0);

        // Zero key with a stray start mid-expansion
        d0 = done_cnt;
        issue(ZERO_KEY, 1'b1);
        repeat (4) @(negedge clk);
        key_in = FIPS_KEY;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_busy", 128'(busy), 128'd1);
        wait_done("zero");
        post_checks("zero", d0);

        // Back-to-back: start in the first IDLE cycle after FIN
        d0 = done_cnt;
        issue(FIPS_KEY, 1'b0);
        wait_done("b2b_first");
        post_checks("b2b_first", d0);
        d0 = done_cnt;
        issue(ZERO_KEY, 1'b1);
        check("b2b_keys_ready_dropped", 128'(keys_ready), 128'd0);
        check("b2b_busy", 128'(busy), 128'd1);
        wait_done("b2b_second");
        post_checks("b2b_second", d0);
        sweep("b2b_store", 1'b1);

        // Asynchronous reset while idx 6 is on the output
        d0 = done_cnt;
        issue(FIPS_KEY, 1'b0);
        repeat (7) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check("midreset_no_done", 128'(done_cnt - d0), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_keys_ready_low", 128'(keys_ready), 128'd0);
        d0 = done_cnt;
        issue(ZERO_KEY, 1'b1);
        wait_done("after_reset");
        post_checks("after_reset", d0);
        rd_idx = 4'd10;
        #1;
        check("after_reset_store10", rd_key, zero_tab[10]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
